card_dealer: RTL and testbench
==============================

Name: card_dealer

Overview:
Card-source controller for the blackjack game FSM. It owns a 52-card deck held as a register array and shuffles it in place with an LFSR-driven Fisher-Yates pass. It serves one card per draw request through a pulse handshake and reshuffles automatically when the deck runs out. It replaces the free-running card_value source feeding the game FSM: each deal, hit and dealer draw issues one draw_req.

Parameters:
DECK_SIZE, 52, cards per deck; fixed at 4 suits x 13 ranks.
LFSR_SEED, 16'hACE1, LFSR value loaded at reset; must be nonzero.
SHUFFLE_EN, 1, 0 bypasses shuffling so the deck stays in identity order (bench use).
LOW_WATER, 10, deck_low asserts when cards_left < LOW_WATER.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
shuffle_req  in  1  one-cycle pulse; reshuffle the full deck
draw_req  in  1  one-cycle pulse; request next card
ready  out  1  high only in READY state (combinational from state)
card_valid  out  1  one-cycle pulse; card_value/card_rank valid
card_value  out  4  blackjack value 1..10 (Ace=1, J/Q/K=10); holds until next card
card_rank  out  4  rank 1..13; holds until next card
cards_left  out  6  undealt cards, 0..52
deck_low  out  1  cards_left < LOW_WATER
shuffling  out  1  high in INIT or SHUFFLE

Behaviour:
- Deck storage: deck[0..51], 6-bit card index per entry. Rank = (idx mod 13)+1. Value = min(rank,10). The array is always a permutation of 0..51.
- LFSR: 16-bit Galois, taps 0xB400, steps every cycle in every state including READY, so user button timing adds entropy. Loaded with LFSR_SEED on reset.
- Reset values: card_valid 0, card_value 0, card_rank 0, cards_left 0, pending 0, top 0, state INIT. Resulting outputs: ready 0, shuffling 1, deck_low 1.
- INIT:
  - Writes deck[k]=k for k=0..51, one entry per cycle (52 cycles).
  - Then goes to SHUFFLE with i=51, or straight to READY if SHUFFLE_EN=0.
- SHUFFLE, one step per cycle:
  - r = lfsr[5:0]. If r <= i: swap deck[i] and deck[r] in the same cycle (combinational reads, two writes), then i <= i-1. Otherwise hold i (rejection sampling).
  - When the step with i==1 completes: top <= 0, cards_left <= 52, go to READY.
- READY:
  - draw_req with cards_left>0: next cycle card_valid=1, card outputs from deck[top], top+1, cards_left-1. Latency is 1 cycle.
  - draw_req with cards_left==0: set pending, go to SHUFFLE (i=51; READY directly if SHUFFLE_EN=0, with top 0 and cards_left 52).
  - pending set on entry to READY: serve the pending card on the first READY cycle (card_valid the following cycle) and clear pending.
  - shuffle_req: go to SHUFFLE, top and cards_left unchanged until shuffle completes. Shuffling the current permutation restores a full deck.
- Simultaneous events:
  - shuffle_req together with draw_req in READY: shuffle wins; the draw is latched as pending and served after the shuffle.
  - draw_req while not ready (INIT/SHUFFLE): latched as pending. The pending store is one deep; further draws while pending is set are dropped.
  - shuffle_req outside READY: ignored.
  - draw_req on the same cycle pending is being served: dropped.
- Reset mid-operation (asserted in any state): immediately returns to INIT and the deck is rebuilt; pending is cleared.
- card_value and card_rank are registered and hold their last value between card_valid pulses.

Decomposition:
- Shared package blackjack_pkg holds:
  - DECK_SIZE and RANKS_PER_SUIT=13
  - dealer state encodings: INIT, SHUFFLE, READY
  - a rank-to-value function (min(rank,10)), also usable by the game FSM.
- One sub-module: lfsr16 (clk, rst, seed, q[15:0]), free-running.

Test Plan:
- SHUFFLE_EN=0, release rst, wait for ready, issue 3 draw_req pulses -> card_rank 1,2,3, card_value 1,2,3, cards_left 51,50,49, card_valid exactly 1 cycle after each request.
- SHUFFLE_EN=0, 13 draws -> 13th card has rank 13, value 10; 14th has rank 1, value 1; deck_low rises when cards_left reaches 9.
- SHUFFLE_EN=1, draw all 52 -> every index 0..51 seen exactly once, each rank seen 4 times; cards_left 0 after the 52nd draw.
- 53rd draw_req at cards_left=0 -> shuffling rises, ready falls; after the shuffle, exactly one card_valid with cards_left=51; a second draw_req issued during the shuffle produces no extra card.
- Same-cycle shuffle_req+draw_req in READY with cards_left=40 -> no card_valid until the shuffle ends, then one card with cards_left=51.
- rst asserted mid-SHUFFLE -> next cycle card_valid 0, cards_left 0, shuffling 1; after release the sequence matches a fresh reset (same seed, same card order).

Source files
------------

// File: rtl/blackjack_pkg.sv
// Shared definitions for the blackjack card source and game FSM.
package blackjack_pkg;

  localparam int DECK_SIZE      = 52;
  localparam int RANKS_PER_SUIT = 13;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    SHUFFLE = 2'd1,
    READY   = 2'd2
  } dealer_state_t;

  function automatic logic [3:0] rank_to_value(input logic [3:0] rank);
    return (rank > 4'd10) ? 4'd10 : rank;
  endfunction

  function automatic logic [3:0] idx_to_rank(input logic [5:0] idx);
    return 4'(idx % 6'(RANKS_PER_SUIT)) + 4'd1;
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR (taps 0xB400), loaded with seed on reset.
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= seed;
    else     q <= (q >> 1) ^ (q[0] ? 16'hB400 : 16'h0000);
  end

endmodule

// File: rtl/card_dealer.sv
// 52-card deck with in-place Fisher-Yates shuffle and a one-card-per-pulse draw handshake.
module card_dealer
  import blackjack_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter bit          SHUFFLE_EN = 1'b1,
  parameter int          LOW_WATER  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       shuffle_req,
  input  logic       draw_req,
  output logic       ready,
  output logic       card_valid,
  output logic [3:0] card_value,
  output logic [3:0] card_rank,
  output logic [5:0] cards_left,
  output logic       deck_low,
  output logic       shuffling
);

  localparam logic [5:0] LAST = 6'(DECK_SIZE - 1);
  localparam logic [5:0] FULL = 6'(DECK_SIZE);

  dealer_state_t state, state_next;
  logic [5:0]  idx, idx_next;
  logic [5:0]  top, top_next;
  logic [5:0]  left_next;
  logic        pending, pending_next;
  logic        serve, init_wr, swap_en;
  logic [15:0] lfsr;
  logic [5:0]  r;
  logic        unused_lfsr;
  logic [5:0]  deck [DECK_SIZE];

  lfsr16 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (LFSR_SEED),
    .q    (lfsr)
  );

  assign r           = lfsr[5:0];
  assign unused_lfsr = ^lfsr[15:6];
  assign ready       = (state == READY);
  assign shuffling   = (state != READY);
  assign deck_low    = (cards_left < 6'(LOW_WATER));

  always_comb begin
    state_next   = state;
    idx_next     = idx;
    top_next     = top;
    left_next    = cards_left;
    pending_next = pending;
    serve        = 1'b0;
    init_wr      = 1'b0;
    swap_en      = 1'b0;
    unique case (state)
      INIT: begin
        init_wr = 1'b1;
        if (draw_req) pending_next = 1'b1;
        if (idx == LAST) begin
          if (SHUFFLE_EN) begin
            state_next = SHUFFLE;
            idx_next   = LAST;
          end else begin
            state_next = READY;
            top_next   = '0;
            left_next  = FULL;
          end
        end else begin
          idx_next = idx + 6'd1;
        end
      end
      SHUFFLE: begin
        if (draw_req) pending_next = 1'b1;
        // out-of-range r is rejected and retried next cycle to keep the shuffle unbiased
        if (r <= idx) begin
          swap_en = 1'b1;
          if (idx == 6'd1) begin
            state_next = READY;
            top_next   = '0;
            left_next  = FULL;
          end else begin
            idx_next = idx - 6'd1;
          end
        end
      end
      READY: begin
        if (shuffle_req) begin
          state_next = SHUFFLE;
          idx_next   = LAST;
          if (draw_req) pending_next = 1'b1;
        end else if (pending) begin
          serve        = 1'b1;
          pending_next = 1'b0;
        end else if (draw_req) begin
          if (cards_left != 6'd0) begin
            serve = 1'b1;
          end else begin
            pending_next = 1'b1;
            if (SHUFFLE_EN) begin
              state_next = SHUFFLE;
              idx_next   = LAST;
            end else begin
              top_next  = '0;
              left_next = FULL;
            end
          end
        end
      end
      default: state_next = INIT;
    endcase
    if (serve) begin
      top_next  = top + 6'd1;
      left_next = cards_left - 6'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= INIT;
      idx        <= '0;
      top        <= '0;
      cards_left <= '0;
      pending    <= 1'b0;
      card_valid <= 1'b0;
      card_value <= '0;
      card_rank  <= '0;
    end else begin
      state      <= state_next;
      idx        <= idx_next;
      top        <= top_next;
      cards_left <= left_next;
      pending    <= pending_next;
      card_valid <= serve;
      if (serve) begin
        card_rank  <= idx_to_rank(deck[top]);
        card_value <= rank_to_value(idx_to_rank(deck[top]));
      end
    end
  end

  // Deck contents need no reset: INIT rebuilds the identity order after every reset.
  always_ff @(posedge clk) begin
    if (init_wr) begin
      deck[idx] <= idx;
    end else if (swap_en) begin
      deck[idx] <= deck[r];
      deck[r]   <= deck[idx];
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Self-checking bench for card_dealer: identity-order instance plus a shuffling instance.
module tb_card_dealer;
  import blackjack_pkg::*;

  localparam logic [15:0] SEED = 16'hACE1;

  logic clk;
  logic rst0, shreq0, drq0, rdy0, cv0, low0, shf0;
  logic rst1, shreq1, drq1, rdy1, cv1, low1, shf1;
  logic [3:0] val0, rank0, val1, rank1;
  logic [5:0] left0, left1;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int draw_no;
    int rank;
    int value;
    int left;
    int low;
  } vec_t;

  vec_t tbl[12];
  int   mrank[52];
  int   n_shuf;

  card_dealer #(.LFSR_SEED(SEED), .SHUFFLE_EN(1'b0), .LOW_WATER(10)) dut0 (
    .clk(clk), .rst(rst0), .shuffle_req(shreq0), .draw_req(drq0),
    .ready(rdy0), .card_valid(cv0), .card_value(val0), .card_rank(rank0),
    .cards_left(left0), .deck_low(low0), .shuffling(shf0)
  );

  card_dealer #(.LFSR_SEED(SEED), .SHUFFLE_EN(1'b1), .LOW_WATER(10)) dut1 (
    .clk(clk), .rst(rst1), .shuffle_req(shreq1), .draw_req(drq1),
    .ready(rdy1), .card_valid(cv1), .card_value(val1), .card_rank(rank1),
    .cards_left(left1), .deck_low(low1), .shuffling(shf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] step16(input logic [15:0] q);
    return (q >> 1) ^ (q[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Reference shuffle: LFSR advances once per INIT cycle, then once per shuffle attempt.
  task automatic build_model;
    int d[52];
    int i, rr, t;
    logic [15:0] q;
    for (int k = 0; k < 52; k++) d[k] = k;
    q = SEED;
    for (int k = 0; k < 52; k++) q = step16(q);
    i = 51;
    n_shuf = 0;
    while (i >= 1 && n_shuf < 20000) begin
      rr = int'(q[5:0]);
      if (rr <= i) begin
        t = d[i]; d[i] = d[rr]; d[rr] = t;
        i--;
      end
      q = step16(q);
      n_shuf++;
    end
    for (int k = 0; k < 52; k++) mrank[k] = (d[k] % 13) + 1;
  endtask

  task automatic until_ready1(input int bound, output int cyc, output int nv, output int lv);
    cyc = 0; nv = 0; lv = -1;
    while (!rdy1 && cyc < bound) begin
      tick;
      cyc++;
      if (cv1) begin nv++; lv = int'(left1); end
    end
  endtask

  task automatic deal_full_deck1(input string tag);
    int cnt[14];
    int rk;
    for (int k = 0; k < 14; k++) cnt[k] = 0;
    for (int d = 0; d < 52; d++) begin
      drq1 = 1'b1;
      tick;
      drq1 = 1'b0;
      check({tag, "_valid"}, int'(cv1), 1);
      rk = int'(rank1);
      check({tag, "_rank"}, rk, mrank[d]);
      check({tag, "_value"}, int'(val1), (mrank[d] > 10) ? 10 : mrank[d]);
      if (rk >= 1 && rk <= 13) cnt[rk]++;
      tick;
    end
    check({tag, "_left_empty"}, int'(left1), 0);
    check({tag, "_low_empty"}, int'(low1), 1);
    for (int k = 1; k <= 13; k++) check({tag, "_rank_count"}, cnt[k], 4);
  endtask

  initial begin
    int cyc, nv, lv, v;

    tbl[0]  = '{1,  1,  1,  51, 0};
    tbl[1]  = '{2,  2,  2,  50, 0};
    tbl[2]  = '{3,  3,  3,  49, 0};
    tbl[3]  = '{10, 10, 10, 42, 0};
    tbl[4]  = '{11, 11, 10, 41, 0};
    tbl[5]  = '{13, 13, 10, 39, 0};
    tbl[6]  = '{14, 1,  1,  38, 0};
    tbl[7]  = '{26, 13, 10, 26, 0};
    tbl[8]  = '{27, 1,  1,  25, 0};
    tbl[9]  = '{42, 3,  3,  10, 0};
    tbl[10] = '{43, 4,  4,  9,  1};
    tbl[11] = '{52, 13, 10, 0,  1};

    build_model;

    rst0 = 1'b1; shreq0 = 1'b0; drq0 = 1'b0;
    rst1 = 1'b1; shreq1 = 1'b0; drq1 = 1'b0;
    repeat (3) tick;

    check("rst_ready",      int'(rdy0),  0);
    check("rst_shuffling",  int'(shf0),  1);
    check("rst_deck_low",   int'(low0),  1);
    check("rst_cards_left", int'(left0), 0);
    check("rst_card_valid", int'(cv0),   0);
    check("rst_card_rank",  int'(rank0), 0);
    check("rst_card_value", int'(val0),  0);
    check("rst1_shuffling", int'(shf1),  1);

    // Identity-order deck
    rst0 = 1'b0;
    cyc = 0;
    while (!rdy0 && cyc < 200) begin tick; cyc++; end
    check("d0_init_cycles", cyc, 52);
    check("d0_left_full", int'(left0), 52);

    v = 0;
    for (int d = 1; d <= 52; d++) begin
      drq0 = 1'b1;
      tick;
      drq0 = 1'b0;
      check("d0_valid_latency", int'(cv0), 1);
      if (v < 12 && tbl[v].draw_no == d) begin
        check("d0_rank",  int'(rank0), tbl[v].rank);
        check("d0_value", int'(val0),  tbl[v].value);
        check("d0_left",  int'(left0), tbl[v].left);
        check("d0_low",   int'(low0),  tbl[v].low);
      end
      tick;
      check("d0_valid_pulse", int'(cv0), 0);
      if (v < 12 && tbl[v].draw_no == d) begin
        check("d0_rank_hold", int'(rank0), tbl[v].rank);
        v++;
      end
    end

    drq0 = 1'b1;
    tick;
    drq0 = 1'b0;
    check("d0_empty_no_card", int'(cv0),   0);
    check("d0_empty_refill",  int'(left0), 52);
    check("d0_empty_ready",   int'(rdy0),  1);
    tick;
    check("d0_pending_valid", int'(cv0),   1);
    check("d0_pending_rank",  int'(rank0), 1);
    check("d0_pending_left",  int'(left0), 51);

    // Shuffled deck
    rst1 = 1'b0;
    cyc = 0;
    while (!rdy1 && cyc < 5000) begin tick; cyc++; end
    check("d1_ready_cycles", cyc, 52 + n_shuf);
    check("d1_shuffling_off", int'(shf1), 0);
    deal_full_deck1("d1_deal");

    drq1 = 1'b1;
    tick;
    drq1 = 1'b0;
    check("d1_exhaust_no_card",   int'(cv1),  0);
    check("d1_exhaust_shuffling", int'(shf1), 1);
    check("d1_exhaust_ready",     int'(rdy1), 0);
    repeat (3) tick;
    drq1 = 1'b1;
    tick;
    drq1 = 1'b0;
    until_ready1(5000, cyc, nv, lv);
    check("d1_reshuffle_done", int'(rdy1), 1);
    repeat (5) begin
      tick;
      if (cv1) begin nv++; lv = int'(left1); end
    end
    check("d1_pending_cards", nv, 1);
    check("d1_pending_left",  lv, 51);

    for (int k = 0; k < 11; k++) begin
      drq1 = 1'b1;
      tick;
      drq1 = 1'b0;
      tick;
    end
    check("d1_left_40", int'(left1), 40);

    shreq1 = 1'b1;
    drq1   = 1'b1;
    tick;
    shreq1 = 1'b0;
    drq1   = 1'b0;
    check("d1_both_no_card",   int'(cv1),   0);
    check("d1_both_shuffling", int'(shf1),  1);
    check("d1_both_left_hold", int'(left1), 40);
    until_ready1(5000, cyc, nv, lv);
    check("d1_both_done", int'(rdy1), 1);
    check("d1_both_early_cards", nv, 0);
    repeat (5) begin
      tick;
      if (cv1) begin nv++; lv = int'(left1); end
    end
    check("d1_both_cards", nv, 1);
    check("d1_both_left",  lv, 51);

    shreq1 = 1'b1;
    tick;
    shreq1 = 1'b0;
    repeat (5) tick;
    check("d1_mid_shuffle", int'(shf1), 1);
    rst1 = 1'b1;
    #1;
    check("d1_rst_valid",     int'(cv1),   0);
    check("d1_rst_left",      int'(left1), 0);
    check("d1_rst_shuffling", int'(shf1),  1);
    check("d1_rst_ready",     int'(rdy1),  0);
    tick;
    check("d1_rst_next_left", int'(left1), 0);
    tick;
    rst1 = 1'b0;
    cyc = 0;
    while (!rdy1 && cyc < 5000) begin tick; cyc++; end
    check("d1_rerst_ready_cycles", cyc, 52 + n_shuf);
    deal_full_deck1("d1_redeal");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
